// File: rtl/occupancy_push_arbiter_pkg.sv
// Shared configuration, derived widths and the arbiter state record for occupancy_push_arbiter.
// Parameter overrides on the top must be mirrored in the ARB_* defaults here, because the widths below derive from them.
package occupancy_push_arbiter_pkg;

    localparam int ARB_NUM_REQ     = 4;
    localparam int ARB_DEPTH       = 4;
    localparam int ARB_MAX_PER_REQ = 2;

    localparam int REQ_IDX_W  = $clog2(ARB_NUM_REQ);
    localparam int COUNT_W    = $clog2(ARB_DEPTH + 1);
    localparam int INFLIGHT_W = $clog2(ARB_MAX_PER_REQ + 1);

    typedef struct packed {
        logic [REQ_IDX_W-1:0] rr_ptr;
        logic [COUNT_W-1:0]   count;
    } arb_state_t;

endpackage

// File: rtl/occupancy_push_arbiter_rr_priority_select.sv
// Combinational round-robin pick: the first eligible index at or after rr_ptr, wrapping.
// Produces a one-hot (or zero) grant and its index, which is 0 when nothing is eligible.
module rr_priority_select
    import occupancy_push_arbiter_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]   eligible,
    input  logic [REQ_IDX_W-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [REQ_IDX_W-1:0] grant_id
);

    logic found;
    int   idx;

    // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && eligible[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = REQ_IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/occupancy_push_arbiter.sv
// Round-robin push arbiter for a shared in-order queue, tracking occupancy and per-requester in-flight entries.
// Optional macro ARB_POP_BYPASS_EN lets a same-cycle pop free a slot (queue-wide and per requester) for a grant.
module occupancy_push_arbiter
    import occupancy_push_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = ARB_NUM_REQ,
    parameter int DEPTH       = ARB_DEPTH,
    parameter int MAX_PER_REQ = ARB_MAX_PER_REQ
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   grant,
    output logic [REQ_IDX_W-1:0] grant_id,
    output logic                 push,
    input  logic                 pop,
    input  logic [REQ_IDX_W-1:0] pop_id,
    output logic [COUNT_W-1:0]   count,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 full
);

    localparam logic [COUNT_W-1:0]    DEPTH_C = COUNT_W'(DEPTH);
    localparam logic [INFLIGHT_W-1:0] MAX_C   = INFLIGHT_W'(MAX_PER_REQ);

    arb_state_t            state_q, state_d;
    logic [INFLIGHT_W-1:0] inflight_q [NUM_REQ];
    logic [INFLIGHT_W-1:0] inflight_d [NUM_REQ];
    logic                  can_push;
    logic [NUM_REQ-1:0]    cap_ok;
    logic [NUM_REQ-1:0]    eligible;

    assign count       = state_q.count;
    assign empty       = (state_q.count == '0);
    assign almost_full = (state_q.count == DEPTH_C - COUNT_W'(1));
    assign full        = (state_q.count == DEPTH_C);

    always_comb begin
        can_push = !full;
        cap_ok   = '0;
`ifdef ARB_POP_BYPASS_EN
        can_push = !full || pop;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            cap_ok[i] = (inflight_q[i] < MAX_C);
`ifdef ARB_POP_BYPASS_EN
            cap_ok[i] = cap_ok[i] || (pop && (pop_id == REQ_IDX_W'(i)));
`endif
        end
        // Grants are forced off while reset is held, even though state only clears on the edge.
        eligible = rst ? (req & cap_ok & {NUM_REQ{can_push}}) : '0;
    end

    rr_priority_select #(
        .NUM_REQ (NUM_REQ)
    ) u_select (
        .eligible (eligible),
        .rr_ptr   (state_q.rr_ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign push = |grant;

    always_comb begin
        state_d = state_q;
        if (push) begin
            state_d.rr_ptr = (grant_id == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + REQ_IDX_W'(1);
        end
        // Saturating updates keep an illegal pop from wrapping the counters.
        case ({push, pop})
            2'b10:   if (state_q.count != DEPTH_C) state_d.count = state_q.count + COUNT_W'(1);
            2'b01:   if (state_q.count != '0)      state_d.count = state_q.count - COUNT_W'(1);
            default: ;
        endcase

        for (int i = 0; i < NUM_REQ; i++) begin
            inflight_d[i] = inflight_q[i];
            if (push && (grant_id == REQ_IDX_W'(i)) && !(pop && (pop_id == REQ_IDX_W'(i)))) begin
                if (inflight_q[i] != MAX_C) inflight_d[i] = inflight_q[i] + INFLIGHT_W'(1);
            end else if (pop && (pop_id == REQ_IDX_W'(i)) && !(push && (grant_id == REQ_IDX_W'(i)))) begin
                if (inflight_q[i] != '0) inflight_d[i] = inflight_q[i] - INFLIGHT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= '0;
            // NOTE: the in-flight array is control state, not storage, so it must be cleared on reset.
            for (int i = 0; i < NUM_REQ; i++) inflight_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(pop && (state_q.count == '0)))       else $warning("underflow");
            assert (!(pop && (inflight_q[pop_id] == '0)))  else $warning("owner underflow");
            assert (!(push && full && !pop))               else $warning("overflow");
            assert ($onehot0(grant))                       else $error("grant not onehot0");
        end
    end

endmodule
